// File: rtl/gb_alu_pkg.sv
// Shared definitions for the gb_alu accumulator ALU: default widths, opcodes,
// and bit positions of the packed flag nibble.
package gb_alu_pkg;

  localparam int ALU_DATA_SIZE = 5;
  localparam int ALU_OP_SIZE   = 3;
  localparam int ALU_RES_SIZE  = 16;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_ADC = 3'd1,
    OP_SUB = 3'd2,
    OP_SBC = 3'd3,
    OP_AND = 3'd4,
    OP_XOR = 3'd5,
    OP_OR  = 3'd6,
    OP_CP  = 3'd7
  } alu_op_e;

  localparam int FLAG_Z = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_H = 1;
  localparam int FLAG_C = 0;

  localparam int RES_FLAG_LSB = 12;

endpackage

// File: rtl/gb_alu_addsub.sv
// Shared adder/subtractor with carry/borrow-in; reports the low-nibble
// half-carry and the full-width carry (borrow when subtracting).
module gb_alu_addsub
  import gb_alu_pkg::*;
#(
  parameter int DATA_SIZE = ALU_DATA_SIZE
) (
  input  logic [DATA_SIZE-1:0] a,
  input  logic [DATA_SIZE-1:0] b,
  input  logic                 cin,
  input  logic                 sub,
  output logic [DATA_SIZE-1:0] r,
  output logic                 half,
  output logic                 carry
);

  logic [DATA_SIZE:0] full;
  logic [4:0]         nib;

  // One extra bit on each path: its top bit is the carry when adding and,
  // being the sign of a non-overflowing difference, the borrow when subtracting.
  always_comb begin
    if (sub) begin
      full = {1'b0, a} - {1'b0, b} - {{DATA_SIZE{1'b0}}, cin};
      nib  = {1'b0, a[3:0]} - {1'b0, b[3:0]} - {4'b0000, cin};
    end else begin
      full = {1'b0, a} + {1'b0, b} + {{DATA_SIZE{1'b0}}, cin};
      nib  = {1'b0, a[3:0]} + {1'b0, b[3:0]} + {4'b0000, cin};
    end
    r     = full[DATA_SIZE-1:0];
    half  = nib[4];
    carry = full[DATA_SIZE];
  end

endmodule

// File: rtl/gb_alu.sv
// Game Boy-style accumulator ALU: combinational packed result {Z,N,H,C,0..,r}
// plus a registered copy of the flags.
module gb_alu
  import gb_alu_pkg::*;
#(
  parameter int DATA_SIZE = ALU_DATA_SIZE,
  parameter int OP_SIZE   = ALU_OP_SIZE,
  parameter int RES_SIZE  = ALU_RES_SIZE
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [OP_SIZE-1:0]   op,
  input  logic [DATA_SIZE-1:0] src_data,
  input  logic [DATA_SIZE-1:0] dest_data,
  input  logic                 ext,
  input  logic                 misc,
  output logic [RES_SIZE-1:0]  res,
  output logic [3:0]           flags_q
);

  alu_op_e              op_sel;
  logic                 as_sub;
  logic                 as_cin;
  logic [DATA_SIZE-1:0] as_r;
  logic                 as_half;
  logic                 as_carry;
  logic [DATA_SIZE-1:0] value;
  logic [DATA_SIZE-1:0] field;
  logic [3:0]           flags;
  logic [3:0]           flags_d;

  assign op_sel = alu_op_e'(op);
  assign as_sub = (op_sel == OP_SUB) || (op_sel == OP_SBC) || (op_sel == OP_CP);
  assign as_cin = ((op_sel == OP_ADC) || (op_sel == OP_SBC)) ? ext : 1'b0;

  gb_alu_addsub #(
    .DATA_SIZE (DATA_SIZE)
  ) u_addsub (
    .a     (dest_data),
    .b     (src_data),
    .cin   (as_cin),
    .sub   (as_sub),
    .r     (as_r),
    .half  (as_half),
    .carry (as_carry)
  );

  always_comb begin
    value = as_r;
    flags = 4'b0000;
    unique case (op_sel)
      OP_ADD, OP_ADC: begin
        flags[FLAG_H] = as_half;
        flags[FLAG_C] = as_carry;
      end
      OP_SUB, OP_SBC, OP_CP: begin
        flags[FLAG_N] = 1'b1;
        flags[FLAG_H] = as_half;
        flags[FLAG_C] = as_carry;
      end
      OP_AND: begin
        value         = dest_data & src_data;
        flags[FLAG_H] = 1'b1;
      end
      OP_XOR: value = dest_data ^ src_data;
      OP_OR:  value = dest_data | src_data;
      default: value = as_r;
    endcase
    flags[FLAG_Z] = (value == '0);

    // CP and flags-only mode keep the accumulator in the result field.
    field = (misc || op_sel == OP_CP) ? dest_data : value;

    res                        = '0;
    res[RES_SIZE-1 -: 4]       = flags;
    res[DATA_SIZE-1:0]         = field;

    flags_d = rst_n ? flags : 4'b0000;
  end

  always_ff @(posedge clk) begin
    flags_q <= flags_d;
  end

endmodule

// File: tb/tb_gb_alu.sv
// Directed-vector bench for gb_alu: the driver queues expected res/flags_q per
// vector, and a negedge monitor pops and compares them.
module tb_gb_alu;
  import gb_alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [4:0]  src_data = 5'd0;
  logic [4:0]  dest_data = 5'd0;
  logic        ext = 1'b0;
  logic        misc = 1'b0;
  logic [15:0] res;
  logic [3:0]  flags_q;

  always #5 clk = ~clk;

  gb_alu dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .op        (op),
    .src_data  (src_data),
    .dest_data (dest_data),
    .ext       (ext),
    .misc      (misc),
    .res       (res),
    .flags_q   (flags_q)
  );

  typedef struct {
    int          id;
    logic [15:0] res;
    logic [3:0]  flg;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  logic drv_vld = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;
  int   vec_id = 0;

  // flg is the flags_q value expected during this vector's cycle, i.e. the
  // flags of the previous vector (or zero after a reset edge).
  task automatic apply(input logic [2:0] o, input logic [4:0] d, input logic [4:0] s,
                       input logic e, input logic m, input logic r,
                       input logic [15:0] exp_res, input logic [3:0] exp_flg);
    @(posedge clk);
    #1;
    op        = o;
    dest_data = d;
    src_data  = s;
    ext       = e;
    misc      = m;
    rst_n     = r;
    drv_vld   = 1'b1;
    sb_q.push_back('{vec_id, exp_res, exp_flg});
    vec_id++;
  endtask

  always @(negedge clk) begin
    if (drv_vld) begin
      if (sb_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL sb_underflow: output presented with no expected entry");
      end else begin
        mon_e = sb_q.pop_front();
        n_chk++;
        if (res !== mon_e.res) begin
          n_fail++;
          $display("FAIL res[v%0d]: got %h expected %h", mon_e.id, res, mon_e.res);
        end
        n_chk++;
        if (flags_q !== mon_e.flg) begin
          n_fail++;
          $display("FAIL flags_q[v%0d]: got %b expected %b", mon_e.id, flags_q, mon_e.flg);
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    //     op      d      s      ext   misc  rst_n res       flags_q
    apply(OP_ADD, 5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 16'h8000, 4'b0000);
    apply(OP_ADD, 5'd20, 5'd15, 1'b0, 1'b0, 1'b1, 16'h3003, 4'b0000);
    apply(OP_SUB, 5'd5,  5'd5,  1'b0, 1'b0, 1'b1, 16'hC000, 4'b0011);
    apply(OP_SBC, 5'd3,  5'd4,  1'b1, 1'b0, 1'b1, 16'h701E, 4'b1100);
    apply(OP_SUB, 5'd3,  5'd4,  1'b1, 1'b0, 1'b1, 16'h701F, 4'b0111);
    apply(OP_AND, 5'd21, 5'd10, 1'b0, 1'b0, 1'b1, 16'hA000, 4'b0111);
    apply(OP_XOR, 5'd21, 5'd10, 1'b0, 1'b0, 1'b1, 16'h001F, 4'b1010);
    apply(OP_CP,  5'd7,  5'd9,  1'b0, 1'b0, 1'b1, 16'h7007, 4'b0000);
    apply(OP_OR,  5'd6,  5'd1,  1'b0, 1'b1, 1'b1, 16'h0006, 4'b0111);
    apply(OP_ADD, 5'd20, 5'd15, 1'b0, 1'b0, 1'b1, 16'h3003, 4'b0000);
    apply(OP_ADD, 5'd20, 5'd15, 1'b0, 1'b0, 1'b0, 16'h3003, 4'b0011);
    apply(OP_ADD, 5'd20, 5'd15, 1'b0, 1'b0, 1'b1, 16'h3003, 4'b0000);
    apply(OP_ADC, 5'd31, 5'd0,  1'b1, 1'b0, 1'b1, 16'hB000, 4'b0011);
    apply(OP_ADD, 5'd31, 5'd0,  1'b1, 1'b0, 1'b1, 16'h001F, 4'b1011);
    apply(OP_SBC, 5'd0,  5'd0,  1'b1, 1'b0, 1'b1, 16'h701F, 4'b0000);
    apply(OP_CP,  5'd5,  5'd5,  1'b0, 1'b0, 1'b1, 16'hC005, 4'b0111);
    apply(OP_ADD, 5'd8,  5'd8,  1'b0, 1'b1, 1'b1, 16'h2008, 4'b1100);
    apply(OP_AND, 5'd31, 5'd31, 1'b0, 1'b0, 1'b1, 16'h201F, 4'b0010);
    apply(OP_ADC, 5'd16, 5'd16, 1'b0, 1'b0, 1'b1, 16'h9000, 4'b0010);
    apply(OP_ADD, 5'd0,  5'd0,  1'b0, 1'b0, 1'b1, 16'h8000, 4'b1001);
    @(posedge clk);
    #1;
    drv_vld = 1'b0;
    repeat (2) @(posedge clk);
    n_chk++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: %0d entries left, expected 0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/gb_alu.md
Name: gb_alu

Overview:
Combinational 5-bit accumulator-style ALU with a Game Boy-like operation set. It computes dest_data OP src_data, packs the result and the Z/N/H/C flags into a 16-bit word, and registers the flags on the clock. It sits in the datapath between the register file (dest_data is the accumulator) and the writeback/flag logic.

Parameters:
DATA_SIZE, 5, operand and result-field width in bits.
OP_SIZE, 3, opcode width.
RES_SIZE, 16, packed result width; must be at least DATA_SIZE+4.

Ports:
clk  input  1  system clock; rising edge samples flags_q.
rst_n  input  1  synchronous, active-low reset.
op  input  OP_SIZE  operation select.
src_data  input  DATA_SIZE  second operand.
dest_data  input  DATA_SIZE  first operand (accumulator).
ext  input  1  carry/borrow-in for ADC and SBC; ignored by other ops.
misc  input  1  flags-only mode: result field returns dest_data.
res  output  RES_SIZE  packed result: {Z,N,H,C, zeros, result[DATA_SIZE-1:0]}.
flags_q  output  4  registered {Z,N,H,C} from the previous cycle.

Behaviour:
- res is purely combinational from op, src_data, dest_data, ext and misc, with zero latency. It is valid within the same cycle and is unaffected by rst_n.
- Layout of res: res[15:12] = {Z,N,H,C}; res[11:5] = 0; res[4:0] = result. Write it generically as the flags in the top 4 bits and the result in the low DATA_SIZE bits.
- Opcodes, with d = dest_data, s = src_data, cin = ext for ADC/SBC and cin = 0 otherwise:
  - 0 ADD: r = d+s.
  - 1 ADC: r = d+s+cin.
  - 2 SUB: r = d-s.
  - 3 SBC: r = d-s-cin.
  - 4 AND: r = d&s.
  - 5 XOR: r = d^s.
  - 6 OR: r = d|s.
  - 7 CP: compute d-s for the flags only; result field = d.
- Arithmetic is evaluated at DATA_SIZE+1 bits; the result field is the low DATA_SIZE bits, so it wraps modulo 32.
- Z: 1 when the computed value (r, or d-s for CP) is 0 mod 32.
- N: 1 for SUB, SBC and CP; 0 otherwise.
- H, for ADD/ADC: 1 when d[3:0]+s[3:0]+cin > 15.
- H, for SUB/SBC/CP: 1 when d[3:0] < s[3:0]+cin, evaluated unsigned at 5 bits.
- H: always 1 for AND; 0 for XOR and OR.
- C, for ADD/ADC: 1 when d+s+cin > 31.
- C, for SUB/SBC/CP: 1 when d < s+cin.
- C: 0 for logical ops.
- misc=1 forces the result field to dest_data for every op. Flags are still computed from the selected op (CP behaviour generalised).
- flags_q:
  - If rst_n=0 at a rising clk edge, flags_q becomes 4'b0000.
  - Otherwise flags_q takes res[15:12] at each rising edge, giving 1-cycle latency.
  - Asserting reset mid-stream loses the stored flags and has no effect on res.
- No X propagation: every op code is defined, so no default-to-X.

Decomposition:
- Package gb_alu_pkg holds:
  - the DATA_SIZE/OP_SIZE/RES_SIZE defaults;
  - the opcode enum (OP_ADD..OP_CP = 0..7);
  - the flag bit indices (FLAG_Z=3, FLAG_N=2, FLAG_H=1, FLAG_C=0);
  - the RES_FLAG_LSB=12 constant.
- One sub-module, gb_alu_addsub, is natural. It is a DATA_SIZE-bit adder/subtractor with cin, producing r, the half-carry and the carry-out. It is shared by ADD/ADC/SUB/SBC/CP.

Test Plan:
- ADD: op=0, d=20, s=15, ext=0, misc=0 -> res=16'h3003 (r=3, H=1, C=1). Next edge: flags_q=4'b0011.
- SUB to zero: op=2, d=5, s=5 -> res=16'hC000 (Z=1, N=1).
- SBC with borrow-in: op=3, d=3, s=4, ext=1 -> res=16'h701E (r=30, N=1, H=1, C=1). Same inputs with op=2, ext ignored -> res=16'h701F.
- Logic: op=4, d=5'b10101, s=5'b01010 -> res=16'hA000 (Z=1, H=1). op=5, same operands -> res=16'h001F.
- CP and misc: op=7, d=7, s=9 -> res=16'h7007. op=6, d=6, s=1, misc=1 -> res=16'h0006.
- Reset: hold rst_n=0 for one edge after ADD with flags_q=4'b0011 -> flags_q=0 while res is still 16'h3003. Release rst_n -> flags_q=4'b0011 on the next edge.
